// File: rtl/q_seq_ctrl.sv
// Sequencer for the ALU's A/Q datapath: shift-add multiply and shift-by-N.
// Issues per-cycle Q/A strobes; only Q[0] is observed from the datapath.
module q_seq_ctrl (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [1:0] op_i,
  input  logic [3:0] n_i,
  input  logic       q_lsb_i,
  output logic       q_load_o,
  output logic       q_en_o,
  output logic       q_dir_o,
  output logic       a_clr_o,
  output logic       a_add_o,
  output logic       a_shift_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o,
  output logic [3:0] iter_o
);

  localparam int unsigned CW    = 4;
  localparam int unsigned ITERS = 8;

  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_SHL = 2'b01;
  localparam logic [1:0] OP_ILL = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_EVAL,
    S_MSHIFT,
    S_SHIFT,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [CW-1:0] n_q, n_d;
  logic [CW-1:0] iter_q, iter_d;
  logic [CW-1:0] n_clip;
  logic [CW-1:0] iter_inc;

  // Shift counts above the word width behave as a full-width shift.
  assign n_clip   = (n_i > CW'(ITERS)) ? CW'(ITERS) : n_i;
  assign iter_inc = iter_q + CW'(1);
  assign iter_o   = iter_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      op_q    <= OP_MUL;
      n_q     <= '0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      n_q     <= n_d;
      iter_q  <= iter_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    n_d       = n_q;
    iter_d    = iter_q;
    q_load_o  = 1'b0;
    q_en_o    = 1'b0;
    q_dir_o   = 1'b0;
    a_clr_o   = 1'b0;
    a_add_o   = 1'b0;
    a_shift_o = 1'b0;
    done_o    = 1'b0;
    err_o     = 1'b0;
    busy_o    = (state_q != S_IDLE);

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          op_d    = op_i;
          n_d     = n_clip;
          state_d = (op_i == OP_ILL) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        q_load_o = 1'b1;
        a_clr_o  = (op_q == OP_MUL);
        iter_d   = '0;
        if (op_q == OP_MUL) begin
          state_d = S_EVAL;
        end else begin
          state_d = (n_q != '0) ? S_SHIFT : S_DONE;
        end
      end
      S_EVAL: begin
        // Only Mealy term: add decision follows the live Q[0].
        a_add_o = q_lsb_i;
        state_d = S_MSHIFT;
      end
      S_MSHIFT: begin
        q_en_o    = 1'b1;
        a_shift_o = 1'b1;
        iter_d    = iter_inc;
        state_d   = (iter_q == CW'(ITERS - 1)) ? S_DONE : S_EVAL;
      end
      S_SHIFT: begin
        q_en_o  = 1'b1;
        q_dir_o = (op_q == OP_SHL);
        iter_d  = iter_inc;
        if (iter_inc == n_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_o  = 1'b1;
        err_o   = (op_q == OP_ILL);
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_q_seq_ctrl.sv
// Self-checking bench for q_seq_ctrl with an A/Q datapath model and
// arithmetic-level expectations (products, shifted words, latencies).
module tb_q_seq_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       start_i;
  logic [1:0] op_i;
  logic [3:0] n_i;
  logic       q_lsb_i;
  logic       q_load_o, q_en_o, q_dir_o, a_clr_o, a_add_o, a_shift_o;
  logic       busy_o, done_o, err_o;
  logic [3:0] iter_o;

  int n_pass  = 0;
  int n_total = 0;

  // Datapath model driven by the sequencer's strobes.
  logic [7:0] qm = 8'h00;
  logic [7:0] am = 8'h00;
  logic       cm = 1'b0;
  logic [7:0] load_val = 8'h00;
  logic [7:0] mcand = 8'h00;
  logic [3:0] last_iter = 4'd0;

  logic [8:0] strobes;
  assign strobes = {q_load_o, q_en_o, q_dir_o, a_clr_o, a_add_o, a_shift_o, busy_o, done_o, err_o};
  assign q_lsb_i = qm[0];

  q_seq_ctrl dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .op_i      (op_i),
    .n_i       (n_i),
    .q_lsb_i   (q_lsb_i),
    .q_load_o  (q_load_o),
    .q_en_o    (q_en_o),
    .q_dir_o   (q_dir_o),
    .a_clr_o   (a_clr_o),
    .a_add_o   (a_add_o),
    .a_shift_o (a_shift_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .err_o     (err_o),
    .iter_o    (iter_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (q_load_o) qm <= load_val;
    if (a_clr_o) begin
      am <= 8'h00;
      cm <= 1'b0;
    end
    if (a_add_o) {cm, am} <= {1'b0, am} + {1'b0, mcand};
    if (q_en_o) begin
      if (q_dir_o) qm <= {qm[6:0], 1'b0};
      else if (a_shift_o) {cm, am, qm} <= {1'b0, cm, am, qm[7:1]};
      else qm <= {1'b0, qm[7:1]};
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Issue one command and compare its whole footprint against the arithmetic rules.
  task automatic run_cmd(input logic [1:0] op, input logic [3:0] n,
                         input logic [7:0] q0, input logic [7:0] m);
    int k, exp_lat, lat, nbusy, nload, nclr, nen, nleft, nshift, nadd, excl;
    logic [7:0] addmask, q_before;
    logic [3:0] iter_done, exp_iter;
    logic       err_done;
    k = (n > 4'd8) ? 8 : int'(n);
    exp_lat = (op == 2'b11) ? 1 : (op == 2'b00) ? 18 : k + 2;
    exp_iter = (op == 2'b11) ? last_iter : (op == 2'b00) ? 4'd8 : 4'(k);
    lat = 0; nbusy = 0; nload = 0; nclr = 0; nen = 0; nleft = 0;
    nshift = 0; nadd = 0; excl = 0; addmask = 8'h00;
    iter_done = 4'hF; err_done = 1'b0;
    @(negedge clk_i);
    op_i = op; n_i = n; load_val = q0; mcand = m; start_i = 1'b1;
    q_before = qm;
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      if (busy_o) nbusy++;
      if (q_load_o) nload++;
      if (a_clr_o) nclr++;
      if (q_en_o) nen++;
      if (q_en_o && q_dir_o) nleft++;
      if (a_shift_o) nshift++;
      if (a_add_o) nadd++;
      if ((q_load_o && q_en_o) || (a_add_o && a_shift_o)) excl++;
      if (op == 2'b00 && c >= 2 && c <= 17 && (c % 2) == 0) addmask[(c - 2) / 2] = a_add_o;
      if (done_o) begin
        lat = c;
        iter_done = iter_o;
        err_done = err_o;
      end
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("busy_cycles", 32'(nbusy), 32'(exp_lat));
    check("q_load_cycles", 32'(nload), (op == 2'b11) ? 32'd0 : 32'd1);
    check("a_clr_cycles", 32'(nclr), (op == 2'b00) ? 32'd1 : 32'd0);
    check("q_en_cycles", 32'(nen), (op == 2'b11) ? 32'd0 : (op == 2'b00) ? 32'd8 : 32'(k));
    check("left_cycles", 32'(nleft), (op == 2'b01) ? 32'(k) : 32'd0);
    check("a_shift_cycles", 32'(nshift), (op == 2'b00) ? 32'd8 : 32'd0);
    check("a_add_cycles", 32'(nadd), (op == 2'b00) ? 32'($countones(q0)) : 32'd0);
    check("exclusion", 32'(excl), 32'd0);
    check("err_at_done", 32'(err_done), 32'(op == 2'b11));
    check("iter_at_done", 32'(iter_done), 32'(exp_iter));
    if (op == 2'b00) check("add_pattern", 32'(addmask), 32'(q0));
    @(negedge clk_i);
    check("idle_strobes", 32'(strobes), 32'd0);
    check("idle_iter", 32'(iter_o), 32'(exp_iter));
    case (op)
      2'b00: check("product", 32'({am, qm}), 32'(16'(q0) * 16'(m)));
      2'b01: check("shl_result", 32'(qm), 32'(8'(q0 << k)));
      2'b10: check("shr_result", 32'(qm), 32'(8'(q0 >> k)));
      default: check("q_untouched", 32'(qm), 32'(q_before));
    endcase
    last_iter = exp_iter;
  endtask

  initial begin
    int dn;
    logic [12:0] dmask, lmask, bmask;
    rst_i = 1'b1; start_i = 1'b0; op_i = 2'b00; n_i = 4'd0;
    repeat (2) @(negedge clk_i);
    check("reset_strobes", 32'(strobes), 32'd0);
    check("reset_iter", 32'(iter_o), 32'd0);
    rst_i = 1'b0;

    run_cmd(2'b00, 4'd0, 8'b1011_0011, 8'h0D);
    check("mul_2327", 32'({am, qm}), 32'h0917);
    run_cmd(2'b01, 4'd3, 8'h01, 8'h00);
    check("shl3_reads_08", 32'(qm), 32'h08);
    run_cmd(2'b10, 4'd12, 8'hA5, 8'h00);
    run_cmd(2'b10, 4'd0, 8'h5A, 8'h00);
    run_cmd(2'b11, 4'd5, 8'hFF, 8'h00);

    // Reset during EVAL of iteration 3 of a multiply.
    @(negedge clk_i);
    op_i = 2'b00; n_i = 4'd0; load_val = 8'hB3; mcand = 8'h0D; start_i = 1'b1;
    repeat (8) begin
      @(negedge clk_i);
      start_i = 1'b0;
    end
    check("pre_rst_iter", 32'(iter_o), 32'd3);
    check("pre_rst_eval", 32'({busy_o, q_en_o, a_shift_o}), 32'b100);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check("rst_strobes", 32'(strobes), 32'd0);
    check("rst_iter", 32'(iter_o), 32'd0);
    dn = 0;
    repeat (20) begin
      @(negedge clk_i);
      if (done_o || busy_o) dn++;
    end
    check("rst_no_done", 32'(dn), 32'd0);
    last_iter = 4'd0;
    run_cmd(2'b01, 4'd2, 8'h81, 8'h00);

    // start held through a SHL-by-2; a SHR-by-1 follows at the first IDLE edge.
    @(negedge clk_i);
    op_i = 2'b01; n_i = 4'd2; load_val = 8'h35; start_i = 1'b1;
    dmask = '0; lmask = '0; bmask = '0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk_i);
      dmask[c] = done_o;
      lmask[c] = q_load_o;
      bmask[c] = busy_o;
      if (c == 4) begin
        op_i = 2'b10;
        n_i = 4'd1;
      end
      if (c == 6) start_i = 1'b0;
    end
    check("hold_done_cycles", 32'(dmask), 32'h0110);
    check("hold_load_cycles", 32'(lmask), 32'h0042);
    check("hold_busy_cycles", 32'(bmask), 32'h01DE);
    check("hold_q_result", 32'(qm), 32'h1A);
    last_iter = 4'd1;

    for (int i = 0; i < 24; i++) begin
      run_cmd(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
              8'($urandom), 8'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
